// File: rtl/stream_offset_monitor.sv
// Event-driven monitor core for a cyclic chain of N streams closed by a negative offset.
// One event is evaluated per period of N+1 cycles, and all streams are published together.
module stream_offset_monitor #(
  parameter int WIDTH = 64,
  parameter int N = 3,
  parameter int OFFSET = 2,
  parameter logic signed [WIDTH-1:0] DEFAULT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     x,
  input  logic                 newX,
  output logic                 outputPhase,
  output logic [N*WIDTH-1:0]   s,
  output logic [N-1:0]         enS
);

  localparam int PW  = $clog2(N + 1);
  localparam int WPW = (OFFSET > 1) ? $clog2(OFFSET) : 1;
  localparam int FW  = $clog2(OFFSET + 1);
  localparam logic [PW-1:0] LAST = PW'(N);

  logic [PW-1:0]           phase;
  logic                    pending;
  logic signed [WIDTH-1:0] xReg;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] offVal;
  logic signed [WIDTH-1:0] newVal;
  logic signed [WIDTH-1:0] shadow [N-1];
  logic signed [WIDTH-1:0] sReg [N];
  logic signed [WIDTH-1:0] hist [OFFSET];
  logic [WPW-1:0]          wp;
  logic [FW-1:0]           fill;
  logic [N-1:0]            enReg;
  logic                    opReg;

  // Once the buffer is full, the slot about to be overwritten holds the value from OFFSET events ago.
  assign offVal = (fill == FW'(OFFSET)) ? hist[wp] : DEFAULT;
  assign newVal = ((phase == PW'(1)) ? offVal : acc) + xReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      pending <= 1'b0;
      xReg    <= '0;
      acc     <= '0;
      wp      <= '0;
      fill    <= '0;
      enReg   <= '0;
      opReg   <= 1'b0;
      for (int k = 0; k < N - 1; k++) shadow[k] <= '0;
      for (int k = 0; k < N; k++) sReg[k] <= '0;
      for (int k = 0; k < OFFSET; k++) hist[k] <= '0;
    end else if (en) begin
      opReg <= 1'b0;
      if (phase == '0) begin
        if (newX) begin
          xReg    <= x;
          pending <= 1'b1;
        end
        phase <= phase + PW'(1);
      end else begin
        if (pending) begin
          acc <= newVal;
          for (int k = 0; k < N - 1; k++)
            if (phase == PW'(k + 1)) shadow[k] <= newVal;
        end
        // The last stream is never parked in a shadow; it goes straight to the outputs and history.
        if (phase == LAST) begin
          phase   <= '0;
          opReg   <= 1'b1;
          pending <= 1'b0;
          if (pending) begin
            for (int k = 0; k < N - 1; k++) sReg[k] <= shadow[k];
            sReg[N-1] <= newVal;
            enReg     <= '1;
            hist[wp]  <= newVal;
            wp        <= (wp == WPW'(OFFSET - 1)) ? '0 : wp + WPW'(1);
            if (fill != FW'(OFFSET)) fill <= fill + FW'(1);
          end else begin
            enReg <= '0;
          end
        end else begin
          phase <= phase + PW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign s[g*WIDTH +: WIDTH] = sReg[g];
  end

  assign enS         = enReg;
  assign outputPhase = opReg;

endmodule

// File: tb/tb_stream_offset_monitor.sv
// Table-driven scoreboard bench for stream_offset_monitor across three parameterisations.
module tb_stream_offset_monitor;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic signed [63:0] x = '0;
  logic              newX0 = 1'b0, newX8 = 1'b0, newX1 = 1'b0;
  logic              op0, op8, op1;
  logic [191:0]      s0w, s1w;
  logic [23:0]       s8w;
  logic [2:0]        en0, en8, en1;

  stream_offset_monitor u0 (
    .clk(clk), .rst(rst), .en(en), .x(x), .newX(newX0),
    .outputPhase(op0), .s(s0w), .enS(en0));

  stream_offset_monitor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .x(x[7:0]), .newX(newX8),
    .outputPhase(op8), .s(s8w), .enS(en8));

  stream_offset_monitor #(.OFFSET(1), .DEFAULT(64'sd5)) u1 (
    .clk(clk), .rst(rst), .en(en), .x(x), .newX(newX1),
    .outputPhase(op1), .s(s1w), .enS(en1));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sel; bit rstBefore; longint xv; bit nv;
    longint e0, e1, e2; logic [2:0] een;
  } vec_t;

  typedef struct {
    longint e0, e1, e2; logic [2:0] een; longint due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   active = 0;
  vec_t tbl[13];

  function automatic vec_t mk(input int sel, input bit r, input longint xv, input bit nv,
                              input longint e0, input longint e1, input longint e2,
                              input logic [2:0] een);
    vec_t v;
    v.sel = sel; v.rstBefore = r; v.xv = xv; v.nv = nv;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.een = een;
    return v;
  endfunction

  task automatic pushExp(input longint e0, input longint e1, input longint e2,
                         input logic [2:0] een, input longint due);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.e2 = e2; e.een = een; e.due = due;
    q.push_back(e);
  endtask

  task automatic checkOutput(input string nm, input longint a0, input longint a1,
                             input longint a2, input logic [2:0] aen, input longint now);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s unexpected pulse at cycle %0d: got s=(%0d,%0d,%0d) enS=%b, required no pulse",
               nm, now, a0, a1, a2, aen);
    end else begin
      e = q.pop_front();
      if (a0 !== e.e0 || a1 !== e.e1 || a2 !== e.e2 || aen !== e.een) begin
        bad++;
        $display("[TB] FAIL %s values: got s=(%0d,%0d,%0d) enS=%b, required s=(%0d,%0d,%0d) enS=%b",
                 nm, a0, a1, a2, aen, e.e0, e.e1, e.e2, e.een);
      end
      total++;
      if (now != e.due) begin
        bad++;
        $display("[TB] FAIL %s pulse cycle: got %0d, required %0d", nm, now, e.due);
      end
    end
  endtask

  // Scoreboard: every outputPhase pulse of the DUT under test consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      case (active)
        0: if (op0) checkOutput("dflt", s0w[63:0], s0w[127:64], s0w[191:128], en0, cyc);
        1: if (op8) checkOutput("w8", longint'($signed(s8w[7:0])), longint'($signed(s8w[15:8])),
                                longint'($signed(s8w[23:16])), en8, cyc);
        default: if (op1) checkOutput("off1", s1w[63:0], s1w[127:64], s1w[191:128], en1, cyc);
      endcase
    end
  end

  task automatic checkReset(input string nm);
    total++;
    if ({op0, en0, s0w, op8, en8, s8w, op1, en1, s1w} !== '0) begin
      bad++;
      $display("[TB] FAIL %s state: got op=%b%b%b enS=%b/%b/%b s0=%h s8=%h s1=%h, required all zero",
               nm, op0, op8, op1, en0, en8, en1, s0w, s8w, s1w);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    newX0 = 1'b0; newX8 = 1'b0; newX1 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkReset("reset");
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int sel, input longint xv, input bit nv,
                               input longint e0, input longint e1, input longint e2,
                               input logic [2:0] een);
    active = sel;
    x = xv;
    newX0 = (sel == 0) && nv;
    newX8 = (sel == 1) && nv;
    newX1 = (sel == 2) && nv;
    pushExp(e0, e1, e2, een, cyc + 4);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    longint t0;
    tbl[0]  = mk(0, 1, 1, 1, 1, 2, 3, 3'b111);
    tbl[1]  = mk(0, 0, 2, 1, 2, 4, 6, 3'b111);
    tbl[2]  = mk(0, 0, 3, 1, 6, 9, 12, 3'b111);
    tbl[3]  = mk(0, 0, 4, 1, 10, 14, 18, 3'b111);
    tbl[4]  = mk(0, 0, 5, 1, 17, 22, 27, 3'b111);
    tbl[5]  = mk(0, 1, 1, 1, 1, 2, 3, 3'b111);
    tbl[6]  = mk(0, 0, 2, 1, 2, 4, 6, 3'b111);
    tbl[7]  = mk(0, 0, 9, 0, 2, 4, 6, 3'b000);
    tbl[8]  = mk(0, 0, 3, 1, 6, 9, 12, 3'b111);
    tbl[9]  = mk(1, 1, 127, 1, 127, -2, 125, 3'b111);
    tbl[10] = mk(1, 0, 1, 1, 1, 2, 3, 3'b111);
    tbl[11] = mk(2, 1, 1, 1, 6, 7, 8, 3'b111);
    tbl[12] = mk(2, 0, 1, 1, 9, 10, 11, 3'b111);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].rstBefore) doReset();
      applyStimulus(tbl[i].sel, tbl[i].xv, tbl[i].nv, tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].een);
    end

    // Three-cycle enable stall in phase 2 stretches the period without changing the values.
    doReset();
    active = 0;
    t0 = cyc;
    x = 1; newX0 = 1'b1;
    pushExp(1, 2, 3, 3'b111, t0 + 7);
    repeat (2) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    applyStimulus(0, 2, 1, 2, 4, 6, 3'b111);

    // Reset during phase 2 of an in-flight event wipes outputs and history.
    doReset();
    applyStimulus(0, 1, 1, 1, 2, 3, 3'b111);
    applyStimulus(0, 2, 1, 2, 4, 6, 3'b111);
    x = 3; newX0 = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkReset("midreset");
    rst = 1'b0;
    applyStimulus(0, 4, 1, 4, 8, 12, 3'b111);

    newX0 = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d outstanding expectations, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
